pwm_capture: RTL and testbench

//  Measures an incoming PWM waveform (motor driver feedback, loopback of our 8-bit PWM output).

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_capture_if.sv | 28 ++
 rtl/pwm_capture_in_cond.sv | 75 +++++++
 rtl/pwm_capture.sv | 158 +++++++++++++++
 tb/tb_pwm_capture.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and FSM state encoding for the PWM capture block.
// No ports. Optional filter macro used by the block: PWM_CAPTURE_FILTER_EN.
package pwm_pkg;

  localparam int CNT_W_DEF       = 11;
  localparam int DUTY_SHIFT_DEF  = 3;
  localparam int PER_W_DEF       = 13;
  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int FILTER_LEN_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: groups the PWM input and the measurement results.
//   pwm_in      raw asynchronous PWM input
//   duty        last measured duty code (8 bit)
//   period      last measured rise-to-rise period in clocks (PER_W bit)
//   valid       one-cycle pulse when duty/period/stuck flags update
//   stuck_high  input held high for at least the timeout
//   stuck_low   input held low for at least the timeout
// master: the capture block. slave: pin driver / register bank side.
interface pwm_capture_if #(
  parameter int PER_W = 13
);
  logic             pwm_in;
  logic [7:0]       duty;
  logic [PER_W-1:0] period;
  logic             valid;
  logic             stuck_high;
  logic             stuck_low;

  modport master (
    input  pwm_in,
    output duty, period, valid, stuck_high, stuck_low
  );

  modport slave (
    output pwm_in,
    input  duty, period, valid, stuck_high, stuck_low
  );
endinterface

// File: rtl/pwm_capture_in_cond.sv
// pwm_in_cond: input conditioning for the PWM capture block.
// Two-flop synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN),
// then edge detect against the registered level.
//   clk, rst  system clock, synchronous active-high reset
//   pwm_in    asynchronous PWM input
//   level     conditioned level, aligned with rise/fall
//   rise      one-cycle strobe on a rising edge
//   fall      one-cycle strobe on a falling edge
// pwm_in to strobe: 3 clocks (3+FILTER_LEN with the filter), same on both edges.
module pwm_in_cond
  import pwm_pkg::*;
#(
`ifdef PWM_CAPTURE_FILTER_EN
  parameter int FILTER_LEN = FILTER_LEN_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_1, sync_2, lvl_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= pwm_in;
      sync_2 <= sync_1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] filt_cnt;
  logic          filt_lvl;

  // The filtered level flips only after FILTER_LEN consecutive samples that
  // disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt <= '0;
      filt_lvl <= 1'b0;
    end else if (sync_2 == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      filt_cnt <= '0;
      filt_lvl <= sync_2;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign lvl_c = filt_lvl;
`else
  assign lvl_c = sync_2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= lvl_c;
      rise  <= lvl_c & ~level;
      fall  <= ~lvl_c & level;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures duty code and rise-to-rise period of a PWM input and
// flags a stuck-high / stuck-low input.
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   pwm_capture_if.master (pwm_in in; duty, period, valid,
//         stuck_high, stuck_low out)
// Optional glitch filter in the input path: define PWM_CAPTURE_FILTER_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for the first rising edge, counters cleared
// ST_HIGH | input high, counting high time and period
// ST_LOW  | input low, counting period; next rise publishes a measurement
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DUTY_SHIFT  = DUTY_SHIFT_DEF,
  parameter int PER_W       = PER_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILTER_LEN = FILTER_LEN_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic level, rise, fall, edge_seen, to_fire;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] high_cnt, high_cnt_nxt;
  logic [PER_W-1:0] per_cnt, per_cnt_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [7:0]       duty_q, duty_nxt;
  logic [PER_W-1:0] period_q, period_nxt;
  logic             valid_q, valid_nxt;
  logic             sh_q, sh_nxt, sl_q, sl_nxt;

  pwm_in_cond
`ifdef PWM_CAPTURE_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
  u_in_cond (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(bus.pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign edge_seen = rise | fall;
  // The counter saturates at TIMEOUT_CYC so a stuck input reports only once.
  // An edge in the same cycle takes priority over the timeout.
  assign to_fire   = (to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !edge_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      high_cnt <= '0;
      per_cnt  <= '0;
      to_cnt   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      sh_q     <= 1'b0;
      sl_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      high_cnt <= high_cnt_nxt;
      per_cnt  <= per_cnt_nxt;
      to_cnt   <= to_cnt_nxt;
      duty_q   <= duty_nxt;
      period_q <= period_nxt;
      valid_q  <= valid_nxt;
      sh_q     <= sh_nxt;
      sl_q     <= sl_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    high_cnt_nxt = high_cnt;
    per_cnt_nxt  = per_cnt;
    to_cnt_nxt   = to_cnt;
    duty_nxt     = duty_q;
    period_nxt   = period_q;
    valid_nxt    = 1'b0;
    sh_nxt       = sh_q;
    sl_nxt       = sl_q;

    if (edge_seen) begin
      to_cnt_nxt = '0;
      sh_nxt     = 1'b0;
      sl_nxt     = 1'b0;
    end else if (to_cnt != TO_W'(TIMEOUT_CYC)) begin
      to_cnt_nxt = to_cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        high_cnt_nxt = '0;
        per_cnt_nxt  = '0;
        if (rise) begin
          state_nxt    = ST_HIGH;
          high_cnt_nxt = CNT_W'(1);
          per_cnt_nxt  = PER_W'(1);
        end
      end
      ST_HIGH: begin
        per_cnt_nxt = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
        if (fall) begin
          state_nxt = ST_LOW;
        end else begin
          high_cnt_nxt = (high_cnt == '1) ? high_cnt : high_cnt + 1'b1;
        end
      end
      ST_LOW: begin
        per_cnt_nxt = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
        if (rise) begin
          // per_cnt holds the clocks from the previous rise up to this one.
          duty_nxt     = 8'(high_cnt >> DUTY_SHIFT);
          period_nxt   = per_cnt;
          valid_nxt    = 1'b1;
          state_nxt    = ST_HIGH;
          high_cnt_nxt = CNT_W'(1);
          per_cnt_nxt  = PER_W'(1);
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        high_cnt_nxt = '0;
        per_cnt_nxt  = '0;
      end
    endcase

    if (to_fire) begin
      duty_nxt     = level ? 8'hFF : 8'h00;
      sh_nxt       = level;
      sl_nxt       = ~level;
      valid_nxt    = 1'b1;
      state_nxt    = ST_IDLE;
      high_cnt_nxt = '0;
      per_cnt_nxt  = '0;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.period     = period_q;
  assign bus.valid      = valid_q;
  assign bus.stuck_high = sh_q;
  assign bus.stuck_low  = sl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM waveforms as (level, length) segments, predicts
// the reported measurements from segment lengths and compares them against
// what the DUT publishes on valid.
module tb_pwm_capture;

  localparam int PER_W      = 13;
  localparam int TIMEOUT    = 4096;
  localparam int HI_MAX     = (1 << 11) - 1;
  localparam int PER_MAX    = (1 << PER_W) - 1;
  localparam int DUTY_DIV   = 8;

  typedef struct {
    int duty;
    int period;
    int sh;
    int sl;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_capture_if #(.PER_W(PER_W)) bus ();

  pwm_capture #(.PER_W(PER_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ev_t exp_q[$];
  ev_t got_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // reference model state
  int m_prev, m_armed, m_hi, m_per, m_last_per, m_sh, m_sl;

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.valid === 1'b1) begin
      ev_t e;
      e.duty   = int'(bus.duty);
      e.period = int'(bus.period);
      e.sh     = int'(bus.stuck_high);
      e.sl     = int'(bus.stuck_low);
      got_q.push_back(e);
    end
  end

  function automatic void model_reset();
    m_prev = 0; m_armed = 0; m_hi = 0; m_per = 0;
    m_last_per = 0; m_sh = 0; m_sl = 0;
  endfunction

  // A segment is a stretch of constant input level lasting len clocks.
  function automatic void model_seg(int lvl, int len);
    ev_t e;
    if (lvl != m_prev) begin
      m_sh = 0;
      m_sl = 0;
      if (lvl == 1) begin
        if (m_armed != 0) begin
          e.duty   = (m_hi > HI_MAX ? HI_MAX : m_hi) / DUTY_DIV;
          e.period = (m_per > PER_MAX) ? PER_MAX : m_per;
          e.sh     = 0;
          e.sl     = 0;
          exp_q.push_back(e);
          m_last_per = e.period;
        end
        m_armed = 1;
        m_hi    = len;
        m_per   = len;
      end else if (m_armed != 0) begin
        m_per += len;
      end
    end else if (m_armed != 0) begin
      m_per += len;
      if (lvl == 1) m_hi += len;
    end
    m_prev = lvl;
    if (len > TIMEOUT + 100) begin
      e.duty   = (lvl == 1) ? 255 : 0;
      e.period = m_last_per;
      e.sh     = (lvl == 1) ? 1 : 0;
      e.sl     = (lvl == 1) ? 0 : 1;
      exp_q.push_back(e);
      m_sh    = e.sh;
      m_sl    = e.sl;
      m_armed = 0;
    end
  endfunction

  task automatic drive(int lvl, int len, bit chk);
    bus.pwm_in = lvl[0];
    for (int i = 0; i < len; i++) begin
      if (chk && i == len - 1 && len >= 16) begin
        @(negedge clk);
        check("stuck_high", int'(bus.stuck_high), m_sh);
        check("stuck_low", int'(bus.stuck_low), m_sl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_seg(int lvl, int len);
    model_seg(lvl, len);
    drive(lvl, len, 1'b1);
  endtask

  task automatic run_frame(int h, int l);
    run_seg(1, h);
    run_seg(0, l);
  endtask

  // High phase with a short low glitch in the middle.
  task automatic run_glitch(int h1, int g, int h2);
`ifdef PWM_CAPTURE_FILTER_EN
    model_seg(1, h1 + g + h2);
`else
    model_seg(1, h1);
    model_seg(0, g);
    model_seg(1, h2);
`endif
    drive(1, h1, 1'b0);
    drive(0, g, 1'b0);
    drive(1, h2, 1'b0);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_duty"}, int'(bus.duty), 0);
    check({tag, "_period"}, int'(bus.period), 0);
    check({tag, "_valid"}, int'(bus.valid), 0);
    check({tag, "_stuck_high"}, int'(bus.stuck_high), 0);
    check({tag, "_stuck_low"}, int'(bus.stuck_low), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // nominal codes on a 2048-clock frame
    run_seg(0, 100);
    for (int i = 0; i < 4; i++) run_frame(512, 1536);
    for (int i = 0; i < 3; i++) run_frame(2040, 8);
    for (int i = 0; i < 3; i++) run_frame(8, 2040);

    // glitch inside the high phase
    run_glitch(200, 2, 310);
    run_seg(0, 1536);
    for (int i = 0; i < 2; i++) run_frame(512, 1536);

    // stuck low, then stuck high
    run_seg(1, 512);
    run_seg(0, 5000);
    run_seg(1, 5000);
    run_seg(0, 300);
    for (int i = 0; i < 2; i++) run_frame(512, 1536);

    // random frames, high time up to past counter saturation
    for (int i = 0; i < 10; i++)
      run_frame(int'($urandom_range(8, 3000)), int'($urandom_range(8, 2000)));

    // reset in the middle of a high phase
    model_seg(1, 300);
    drive(1, 300, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("rst_mid");
    bus.pwm_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_seg(0, 500);
    for (int i = 0; i < 3; i++) run_frame(512, 1536);
    run_seg(1, 100);
    run_seg(0, 300);

    check("event_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("ev%0d_duty", i), got_q[i].duty, exp_q[i].duty);
      check($sformatf("ev%0d_period", i), got_q[i].period, exp_q[i].period);
      check($sformatf("ev%0d_stuck_high", i), got_q[i].sh, exp_q[i].sh);
      check($sformatf("ev%0d_stuck_low", i), got_q[i].sl, exp_q[i].sl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
